// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses and operation encoding shared by the Zicsr write path.
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: wide counter whose halves can be written; a write overrides the increment.
module csr_counter64 #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // write replaces one half and freezes the other; otherwise count with natural wrap
  always_comb
    cnt_d = (wr_lo | wr_hi) ? {wr_hi ? wdata : cnt_q[CNT_W-1:XLEN], wr_lo ? wdata : cnt_q[XLEN-1:0]}
          : inc ? cnt_q + CNT_W'(1) : cnt_q;

  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;

endmodule

// File: rtl/csr_rw_file.sv
// csr_rw_file: Zicsr read/modify/write of cycle, instret and mscratch in EX.
module csr_rw_file
  import csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 64,
  parameter logic [XLEN-1:0] MSCRATCH_RST = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_src,
  input  logic            csr_src_zero,
  input  logic            stall,
  input  logic            flush,
  input  logic            inst_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            csr_wr_done
);

  csr_op_e          op;
  logic [CNT_W-1:0] cycle, instret;
  logic [XLEN-1:0]  mscratch_q, mscratch_d, old, wdata;
  logic             wr_done_q, wr_done_d;
  logic             mapped, ro, we, commit;

  assign op = csr_op_e'(csr_op);

  // decode the address into the current CSR value; unmapped reads as zero
  always_comb begin
    old    = '0;
    mapped = 1'b1;
    case (csr_addr)
      CSR_MCYCLE,    CSR_CYCLE:    old = cycle[XLEN-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   old = cycle[CNT_W-1:XLEN];
      CSR_MINSTRET,  CSR_INSTRET:  old = instret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: old = instret[CNT_W-1:XLEN];
      CSR_MSCRATCH:                old = mscratch_q;
      default:                     mapped = 1'b0;
    endcase
  end

  // the C-range aliases are user read-only views of the machine counters
  assign ro          = csr_addr[11:10] == 2'b11;
  assign we          = csr_valid & (op == CSR_RW | ((op == CSR_RS | op == CSR_RC) & !csr_src_zero));
  assign csr_illegal = csr_valid & (op != CSR_NONE) & (!mapped | (we & ro));
  assign commit      = we & !csr_illegal & !stall & !flush;
  assign wdata       = op == CSR_RS ? old | csr_src : op == CSR_RC ? old & ~csr_src : csr_src;
  assign csr_rdata   = csr_valid ? old : '0;

  // next state for mscratch and the commit pulse
  always_comb begin
    mscratch_d = (commit & csr_addr == CSR_MSCRATCH) ? wdata : mscratch_q;
    wr_done_d  = commit;
  end

  // mscratch and write-done registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mscratch_q <= MSCRATCH_RST;
      wr_done_q  <= 1'b0;
    end else begin
      mscratch_q <= mscratch_d;
      wr_done_q  <= wr_done_d;
    end

  assign csr_wr_done = wr_done_q;

  csr_counter64 #(.XLEN(XLEN), .CNT_W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (commit & csr_addr == CSR_MCYCLE),
    .wr_hi (commit & csr_addr == CSR_MCYCLEH),
    .wdata (wdata),
    .cnt   (cycle)
  );

  csr_counter64 #(.XLEN(XLEN), .CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inst_retire & !stall),
    .wr_lo (commit & csr_addr == CSR_MINSTRET),
    .wr_hi (commit & csr_addr == CSR_MINSTRETH),
    .wdata (wdata),
    .cnt   (instret)
  );

endmodule
